// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length encoding, mode constants, GF(2^8) helpers
// and the forward S-box table used by both the key schedule and the cipher.
package aes_pkg;

  typedef enum logic [1:0] {
    KL_128 = 2'd0,
    KL_192 = 2'd1,
    KL_256 = 2'd2,
    KL_RSV = 2'd3
  } key_len_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GEN   = 2'd1,
    ST_DRAIN = 2'd2
  } ks_state_t;

  function automatic logic [3:0] nk(input key_len_t kl);
    case (kl)
      KL_192:  return 4'd6;
      KL_256:  return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr(input key_len_t kl);
    case (kl)
      KL_192:  return 4'd12;
      KL_256:  return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word (combinational).
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign dout[8*b +: 8] = SBOX[din[8*b +: 8]];
  end

endmodule

// File: rtl/aes_key_sched.sv
// Iterative AES-128/192/256 key expansion: one expanded word per cycle from a
// sliding window of the last Nk words, round keys emitted on a valid/ready port.
module aes_key_sched
  import aes_pkg::*;
#(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_idx,
  output logic [127:0] rk_data,
  output logic         done,
  output logic         err
);

  ks_state_t   state, state_nx;
  key_len_t    kl;
  logic [31:0] win [8];
  logic [5:0]  i;
  logic [2:0]  j;
  logic [7:0]  rcon;
  logic [3:0]  nxt_r;

  key_len_t    kl_in;
  logic [3:0]  nk_in, nk_cur, nr_cur;
  logic        kl_ok;
  logic [7:0]  key_sh;
  logic [255:0] key_al;

  assign kl_in  = key_len_t'(key_len);
  assign nk_in  = nk(kl_in);
  assign nk_cur = nk(kl);
  assign nr_cur = nr(kl);
  assign kl_ok  = (kl_in != KL_RSV) && (int'(nk_in) * 32 <= MAX_KEY_BITS);
  // Right-justify the key so w(Nk-1) lands in the newest window slot.
  assign key_sh = {3'(4'd8 - nk_in), 5'd0};
  assign key_al = key_in >> key_sh;

  logic        stall, j_last, pending, complete;
  logic [2:0]  old_sel;
  logic [5:0]  rk_last, last_w;
  logic [31:0] prev, sub_in, sub_out, temp, new_w;

  assign stall    = rk_valid & ~rk_ready;
  assign j_last   = ({1'b0, j} == nk_cur - 4'd1);
  assign old_sel  = 3'(4'd8 - nk_cur);
  assign rk_last  = {nxt_r, 2'b11};
  assign last_w   = {nr_cur, 2'b11};
  // A round whose last word already exists is waiting only for the output slot.
  assign pending  = rk_last < i;
  assign complete = rk_last == i;

  assign prev   = win[7];
  assign sub_in = (j == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

  aes_sub_word u_sub_word (
    .din  (sub_in),
    .dout (sub_out)
  );

  always_comb begin
    temp = prev;
    if (j == 3'd0)
      temp = sub_out ^ {rcon, 24'h0};
    else if (nk_cur == 4'd8 && j == 3'd4)
      temp = sub_out;
  end

  assign new_w = win[old_sel] ^ temp;

  logic accept, reject, gen_en, finish;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    reject   = 1'b0;
    gen_en   = 1'b0;
    finish   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (kl_ok) begin
            accept   = 1'b1;
            state_nx = ST_GEN;
          end else begin
            reject   = 1'b1;
          end
        end
      end
      ST_GEN: begin
        if (!stall) begin
          gen_en = 1'b1;
          if (i == last_w) state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (rk_ready) begin
          finish   = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) win[k] <= '0;
      kl       <= KL_128;
      i        <= '0;
      j        <= '0;
      rcon     <= '0;
      nxt_r    <= '0;
      rk_valid <= 1'b0;
      rk_idx   <= '0;
      rk_data  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= reject;
      if (accept) begin
        for (int k = 0; k < 8; k++) win[k] <= key_al[32*(7-k) +: 32];
        kl       <= kl_in;
        i        <= {2'b00, nk_in};
        j        <= '0;
        rcon     <= 8'h01;
        nxt_r    <= 4'd1;
        rk_valid <= 1'b1;
        rk_idx   <= '0;
        rk_data  <= key_in[255:128];
      end else if (gen_en) begin
        for (int k = 0; k < 7; k++) win[k] <= win[k+1];
        win[7] <= new_w;
        i      <= i + 6'd1;
        j      <= j_last ? 3'd0 : j + 3'd1;
        if (j == 3'd0) rcon <= xtime(rcon);
        if (pending) begin
          rk_data  <= {win[4], win[5], win[6], win[7]};
          rk_idx   <= nxt_r;
          rk_valid <= 1'b1;
          nxt_r    <= nxt_r + 4'd1;
        end else if (complete) begin
          rk_data  <= {win[5], win[6], win[7], new_w};
          rk_idx   <= nxt_r;
          rk_valid <= 1'b1;
          nxt_r    <= nxt_r + 4'd1;
        end else begin
          rk_valid <= 1'b0;
        end
      end else if (finish) begin
        rk_valid <= 1'b0;
        done     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_sched.sv
// Scoreboard bench for aes_key_sched: FIPS-197 vectors plus an independent
// expansion model whose S-box is derived from GF(2^8) inversion.
module tb_aes_key_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic         busy, rk_valid, rk_ready, done, err;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;

  always #5 clk = ~clk;

  aes_key_sched #(.MAX_KEY_BITS(256)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key_len  (key_len),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_idx   (rk_idx),
    .rk_data  (rk_data),
    .done     (done),
    .err      (err)
  );

  typedef struct {
    int           idx;
    logic [127:0] data;
    int           t;
    bit           last;
  } exp_t;

  exp_t q[$];
  int total = 0, bad = 0;
  int cyc = 0, e0 = 0, done_cnt = 0, err_cnt = 0;
  bit exp_done = 0;
  logic [7:0] sb [256];

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endfunction

  function automatic void chk1(input string name, input logic act, input logic want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, want);
    end
  endfunction

  function automatic void chki(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  task automatic push_model(input logic [1:0] kl, input logic [255:0] key, input bit timed,
                            input bit kat1_en, input logic [127:0] kat1, input logic [127:0] katn);
    int nkv, nrv, lat;
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0] rc;
    exp_t e;
    nkv = (kl == 2'd0) ? 4 : (kl == 2'd1) ? 6 : 8;
    nrv = nkv + 6;
    for (int m = 0; m < nkv; m++) w[m] = key[255-32*m -: 32];
    rc = 8'h01;
    for (int k = nkv; k < 4*(nrv+1); k++) begin
      t = w[k-1];
      if (k % nkv == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nkv == 8 && k % 8 == 4) begin
        t = subw(t);
      end
      w[k] = w[k-nkv] ^ t;
    end
    for (int r = 0; r <= nrv; r++) begin
      e.idx  = r;
      e.data = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      if (r == 1 && kat1_en) e.data = kat1;
      if (r == nrv) e.data = katn;
      lat    = (r > 4*r+4-nkv) ? r : 4*r+4-nkv;
      e.t    = timed ? lat : -1;
      e.last = (r == nrv);
      q.push_back(e);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_done = 0;
      end else begin
        if (exp_done || done) begin
          chk1("done_pulse", done, exp_done);
          chk1("busy_with_done", busy, 1'b0);
        end
        exp_done = 0;
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (rk_valid && rk_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_rk", rk_data, 128'h0);
          end else begin
            e = q.pop_front();
            chki("rk_idx", int'(rk_idx), e.idx);
            chk("rk_data", rk_data, e.data);
            if (e.t >= 0) chki("rk_cycle", cyc - e0, e.t);
            if (e.last) exp_done = 1;
          end
        end
      end
    end
  end

  task automatic run(input logic [1:0] kl, input logic [255:0] key, input bit thr, input bit mid,
                     input bit kat1_en, input logic [127:0] kat1, input logic [127:0] katn,
                     input int abort_at);
    int  done_base, err_base;
    bit  got;
    push_model(kl, key, !thr, kat1_en, kat1, katn);
    @(posedge clk); #1;
    start    = 1'b1;
    key_len  = kl;
    key_in   = key;
    rk_ready = 1'b1;
    e0       = cyc + 1;
    done_base = done_cnt;
    err_base  = err_cnt;
    got = 0;
    for (int n = 0; n < 800; n++) begin
      @(posedge clk); #1;
      if (n == 0) begin
        start = 1'b0;
        chk1("busy_rise", busy, 1'b1);
      end
      if (mid && n == 10) begin start = 1'b1; key_len = 2'd2; key_in = ~key; end
      if (mid && n == 12) begin key_len = 2'd3; end
      if (mid && n == 13) begin start = 1'b0; key_len = kl; key_in = key; end
      if (abort_at > 0 && n == abort_at) begin
        q.delete();
        rst_n = 1'b0;
        #1;
        chk1("abort_rk_valid", rk_valid, 1'b0);
        chki("abort_rk_idx", int'(rk_idx), 0);
        chk("abort_rk_data", rk_data, 128'h0);
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_done", done, 1'b0);
        chk1("abort_err", err, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chki("abort_no_done", done_cnt - done_base, 0);
        chk1("abort_idle", busy, 1'b0);
        return;
      end
      if (done) begin
        got = 1;
        chk1("busy_fall", busy, 1'b0);
        break;
      end
      if (thr) rk_ready = ($urandom_range(0, 2) == 0);
    end
    if (!got) chk1("run_timeout", 1'b0, 1'b1);
    rk_ready = 1'b1;
    @(posedge clk); #1;
    chki("queue_empty", q.size(), 0);
    chki("done_count", done_cnt - done_base, 1);
    chki("no_err_in_run", err_cnt - err_base, 0);
  endtask

  initial begin
    logic [7:0] inv, b;
    rst_n    = 1'b0;
    start    = 1'b0;
    key_len  = 2'd0;
    key_in   = '0;
    rk_ready = 1'b1;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      repeat (254) inv = gmul(inv, 8'(x));
      b = inv;
      sb[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end

    repeat (3) @(posedge clk);
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_rk_valid", rk_valid, 1'b0);
    chki("rst_rk_idx", int'(rk_idx), 0);
    chk("rst_rk_data", rk_data, 128'h0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    rst_n = 1'b1;

    run(2'd0, K128, 0, 0, 1, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 0);
    run(2'd1, K192, 0, 0, 0, 128'h0,
        128'he98ba06f448c773c8ecc720401002202, 0);
    run(2'd2, K256, 0, 0, 1, 128'h1f352c073b6108d72d9810a30914dff4,
        128'hfe4890d1e6188d0b046df344706c631e, 0);
    run(2'd2, K256, 1, 0, 1, 128'h1f352c073b6108d72d9810a30914dff4,
        128'hfe4890d1e6188d0b046df344706c631e, 0);

    @(posedge clk); #1;
    start   = 1'b1;
    key_len = 2'd3;
    key_in  = K128;
    @(posedge clk); #1;
    start = 1'b0;
    chk1("err_pulse", err, 1'b1);
    chk1("err_busy", busy, 1'b0);
    chk1("err_rk_valid", rk_valid, 1'b0);
    @(posedge clk); #1;
    chk1("err_one_cycle", err, 1'b0);
    chk1("err_busy_after", busy, 1'b0);

    run(2'd0, K128, 0, 1, 1, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 0);
    run(2'd0, K128, 0, 0, 1, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 20);
    run(2'd0, K128, 0, 0, 1, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_key_sched.md
# aes_key_sched

Iterative, parametrised AES key schedule supporting AES-128, AES-192 and AES-256 on one datapath. It generates one 32-bit expanded-key word per cycle and emits 128-bit round keys in order as a valid/ready stream. It sits between the key register and the round pipeline, which consumes round keys as they arrive. Only four S-boxes are used, and only the last Nk words are kept in a sliding window.

## Interface
- `MAX_KEY_BITS`, default 256: largest supported key (128, 192 or 256). A `key_len` above this is rejected.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; accepted only when `busy`=0.
- `key_len` in 2: 0 = 128, 1 = 192, 2 = 256; 3 is reserved. Sampled at start.
- `key_in` in 256: key, left-aligned; `w0` = `key_in[255:224]`. Unused LSBs are ignored. Sampled at start.
- `busy` out 1: expansion in progress.
- `rk_valid` out 1: round key present on the output.
- `rk_ready` in 1: consumer accepts the current round key.
- `rk_idx` out 4: round number of `rk_data`, from 0 to Nr.
- `rk_data` out 128: `{w[4r], w[4r+1], w[4r+2], w[4r+3]}`.
- `done` out 1: one-cycle pulse on the handshake of the final round key.
- `err` out 1: one-cycle pulse when a start is rejected.

## Operation
- Mode constants: Nk = 4, 6, 8; Nr = 10, 12, 14; total words = 4(Nr+1) = 44, 52, 60.
- States: IDLE, GEN, DRAIN.
- IDLE to GEN on `start` with a legal `key_len`:
  - load w0..w(Nk-1) into the window;
  - set word counter i = Nk and rcon = 0x01;
  - latch the mode.
- Illegal `key_len` (3, or above `MAX_KEY_BITS`): stay in IDLE, pulse `err`, outputs unchanged.
- In GEN, each non-stalled cycle produces word i:
  - temp = w(i-1);
  - if i mod Nk = 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}, then rcon = xtime(rcon) (0x80 → 0x1b, 0x1b → 0x36);
  - else if Nk = 8 and i mod 8 = 4: temp = SubWord(temp);
  - w(i) = w(i-Nk) ^ temp; shift it into the window; i++.
- Round key r is presented as soon as w(4r+3) exists and round r-1 has been presented. AES-256 round 1 (w4..w7 from the key) is therefore presented in the first GEN cycle, not alongside round 0.
- Output register holds one round key. While `rk_valid`=1 and `rk_ready`=0, generation and the window freeze. There is no skipping and no overwrite.
- After the last word is generated: go to DRAIN and wait for the final handshake. Then `done`=1, return to IDLE, and `busy`=0 in the same cycle `done` is seen.
- `start` while `busy`=1 is ignored (no `err`).
- Reset mid-run aborts immediately; no `done` is produced.
- All arithmetic is XOR in GF(2^8). The word counter is 6 bits wide.

## Timing
- Reset values: `busy`=0, `rk_valid`=0, `rk_idx`=0, `rk_data`=0, `done`=0, `err`=0. Window, counter and rcon are 0; state is IDLE.
- Let E0 be the edge that accepts `start`. With `rk_ready` held at 1, round key r is valid after edge E(max(r, 4r+4-Nk)).
  - AES-128: rk0 after E0, rk1 after E4, rk10 after E40.
  - AES-192: rk1 after E2, rk12 after E46.
  - AES-256: rk1 after E1, rk2 after E4, rk14 after E52.
- `busy` rises after E0 and falls at the edge of the final handshake.
- Each cycle `rk_ready` is low adds exactly one cycle to every later event.
- A new `start` may be issued in the cycle after `done`.

## Structure
- Package `aes_pkg` holds:
  - `key_len_t` enum;
  - functions `nk(key_len)` and `nr(key_len)`;
  - `xtime`;
  - the S-box constant table, shared with the cipher.
- Sub-module `aes_sub_word`: combinational, 32-bit in and out, four S-box lookups. Instantiate it once; it is shared between the RotWord and plain SubWord cases.

## Test plan
- AES-128, FIPS-197 key `2b7e1516_28aed2a6_abf71588_09cf4f3c`, `rk_ready`=1 → rk1 = `a0fafe17_88542cb1_23a33939_2a6c7605` after E4; rk10 = `d014f9a8_c9ee2589_e13f0cc8_b6630ca6` after E40 with `done`.
- AES-192, key `8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b` → 13 keys, rk_idx 0..12; rk12 = `e98ba06f_448c773c_8ecc7204_01002202` after E46.
- AES-256, key `603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4` → rk1 = `1f352c07_3b6108d7_2d9810a3_0914dff4` after E1; rk14 = `fe4890d1_e6188d0b_046df344_706c631e` after E52.
- Backpressure: random `rk_ready` throttling on AES-256 → identical key sequence, no gaps or duplicates in `rk_idx`, `done` exactly once.
- `key_len`=3 → `err` pulse, `busy` stays 0. `start` issued mid-run → ignored; output sequence unchanged.
- `rst_n` asserted at E20 of an AES-128 run → all outputs at reset values immediately. A fresh start afterwards reproduces the first scenario exactly.
